// File: rtl/dct_block_sequencer_pkg.sv
// Shared constants and types for the EEG DCT block sequencer.
package dct_block_sequencer_pkg;

  localparam int unsigned BLK_LEN  = 8;
  localparam int unsigned SAMP_W   = 8;
  localparam int unsigned COEF_W   = 12;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned BLKCNT_W = 16;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  typedef logic signed [SAMP_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  // One coefficient beat presented to the RLE encoder.
  typedef struct packed {
    logic             last;
    logic [IDX_W-1:0] idx;
    coef_t            coef;
  } coef_beat_t;

endpackage

// File: rtl/dct_block_sequencer_if.sv
// Sample-in and coefficient-out handshakes of the DCT block sequencer.
interface dct_block_sequencer_if;
  import dct_block_sequencer_pkg::*;

  logic             in_valid;
  logic             in_ready;
  sample_t          in_sample;
  logic             out_valid;
  logic             out_ready;
  coef_t            out_coef;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport slave (
    input  in_valid, in_sample, out_ready,
    output in_ready, out_valid, out_coef, out_idx, out_last
  );

  modport master (
    output in_valid, in_sample, out_ready,
    input  in_ready, out_valid, out_coef, out_idx, out_last
  );

endinterface

// File: rtl/dct_block_sequencer_coef_drain_reg.sv
// Coefficient capture bank and serial valid/ready drain, in index order.
module coef_drain_reg
  import dct_block_sequencer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     capture,
  input  logic                     drain,
  input  logic [BLK_LEN*COEF_W-1:0] z,
  input  logic                     out_ready,
  output logic                     out_valid,
  output coef_t                    out_coef,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     done_c
);

  logic [BLK_LEN-1:0][COEF_W-1:0] coef_q;
  logic [IDX_W-1:0]               rd_ptr;
  logic [IDX_W-1:0]               rd_nxt;
  coef_beat_t                     beat_q;

  assign rd_nxt   = rd_ptr + IDX_W'(1);
  assign done_c   = out_valid && out_ready && beat_q.last;
  assign out_coef = beat_q.coef;
  assign out_idx  = beat_q.idx;
  assign out_last = beat_q.last;

  // Capture the whole DCT result in one cycle; layout matches dct_z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_q <= '0;
    end else if (capture) begin
      coef_q <= z;
    end
  end

  // Present coef[rd_ptr]; advance on each accepted beat, holding under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rd_ptr    <= '0;
      beat_q    <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
      rd_ptr    <= '0;
      beat_q    <= '0;
    end else if (capture) begin
      rd_ptr <= '0;
    end else if (drain) begin
      if (!out_valid) begin
        out_valid   <= 1'b1;
        beat_q.coef <= coef_t'(coef_q[rd_ptr]);
        beat_q.idx  <= rd_ptr;
        beat_q.last <= (rd_ptr == IDX_W'(BLK_LEN - 1));
      end else if (out_ready) begin
        if (beat_q.last) begin
          out_valid <= 1'b0;
          rd_ptr    <= '0;
        end else begin
          rd_ptr      <= rd_nxt;
          beat_q.coef <= coef_t'(coef_q[rd_nxt]);
          beat_q.idx  <= rd_nxt;
          beat_q.last <= (rd_nxt == IDX_W'(BLK_LEN - 1));
        end
      end
    end
  end

endmodule

// File: rtl/dct_block_sequencer.sv
// Assembles 8-sample blocks, sequences the DCT datapath and streams coefficients.
module dct_block_sequencer
  import dct_block_sequencer_pkg::*;
#(
  parameter int unsigned DCT_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  dct_block_sequencer_if.slave      bus,
  output logic                      dct_en,
  output logic                      dct_cs,
  output logic [BLK_LEN*SAMP_W-1:0] dct_x,
  input  logic [BLK_LEN*COEF_W-1:0] dct_z,
  output logic                      busy,
  output logic [BLKCNT_W-1:0]       blk_cnt
);

  state_e                         state;
  logic [IDX_W-1:0]               wr_ptr;
  logic [CNT_W-1:0]               wait_cnt;
  logic [BLK_LEN-1:0][SAMP_W-1:0] samp_buf;
  logic                           accept_c;
  logic                           capture_c;
  logic                           drain_c;
  logic                           done_c;

  assign accept_c  = bus.in_valid && bus.in_ready && (state == ST_FILL) && !clr;
  assign capture_c = (state == ST_WAIT) && (wait_cnt == '0) && !clr;
  assign drain_c   = (state == ST_DRAIN) && !clr;

  // Sample buffer is written only while filling, so dct_x is stable during the DCT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_buf <= '0;
    end else if (accept_c) begin
      samp_buf[wr_ptr] <= bus.in_sample;
    end
  end

  assign dct_x = samp_buf;

  // Block sequencing FSM with registered handshake and DCT controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_FILL;
      wr_ptr       <= '0;
      wait_cnt     <= '0;
      bus.in_ready <= 1'b1;
      dct_en       <= 1'b0;
      dct_cs       <= 1'b0;
      busy         <= 1'b0;
      blk_cnt      <= '0;
    end else if (clr) begin
      state        <= ST_FILL;
      wr_ptr       <= '0;
      wait_cnt     <= '0;
      bus.in_ready <= 1'b1;
      dct_en       <= 1'b0;
      dct_cs       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept_c) begin
            wr_ptr <= wr_ptr + IDX_W'(1);
            if (wr_ptr == IDX_W'(BLK_LEN - 1)) begin
              state        <= ST_LAUNCH;
              bus.in_ready <= 1'b0;
              dct_en       <= 1'b1;
              dct_cs       <= 1'b1;
              busy         <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          wait_cnt <= CNT_W'(DCT_LAT - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state  <= ST_DRAIN;
            dct_en <= 1'b0;
            dct_cs <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (done_c) begin
            state        <= ST_FILL;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
            blk_cnt      <= blk_cnt + BLKCNT_W'(1);
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  coef_drain_reg u_drain (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .capture   (capture_c),
    .drain     (drain_c),
    .z         (dct_z),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_coef  (bus.out_coef),
    .out_idx   (bus.out_idx),
    .out_last  (bus.out_last),
    .done_c    (done_c)
  );

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Scoreboard bench for dct_block_sequencer with a latency-accurate DCT model.
module tb_dct_block_sequencer;

  localparam int LAT = 3;

  typedef struct packed {
    logic [11:0] coef;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        dct_en, dct_cs, busy;
  logic [63:0] dct_x;
  logic [95:0] dct_z;
  logic [15:0] blk_cnt;
  logic        mode = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cnt = 0;
  int cs_cnt = 0;
  int t_acc = 0;
  int exp_blk = 0;

  logic [7:0] stim_q[$];
  logic [7:0] acc_q[$];
  beat_t      exp_q[$];
  logic [95:0] zpipe [LAT];

  dct_block_sequencer_if bus();

  dct_block_sequencer #(.DCT_LAT(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .bus     (bus),
    .dct_en  (dct_en),
    .dct_cs  (dct_cs),
    .dct_x   (dct_x),
    .dct_z   (dct_z),
    .busy    (busy),
    .blk_cnt (blk_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dct_en === 1'b1) en_cnt <= en_cnt + 1;
    if (dct_cs === 1'b1) cs_cnt <= cs_cnt + 1;
  end

  // Mode 0: Zk = k*100. Mode 1: Zk = 4*xk + k, which exposes the dct_x packing.
  function automatic logic [95:0] dct_f(input logic [63:0] x, input logic m);
    logic [95:0] z;
    logic [7:0]  s;
    z = '0;
    for (int k = 0; k < 8; k++) begin
      s = x[8*k +: 8];
      if (m) z[12*k +: 12] = 12'(int'($signed(s)) * 4 + k);
      else   z[12*k +: 12] = 12'(k * 100);
    end
    return z;
  endfunction

  // DCT pipeline: result appears LAT cycles after the first enabled cycle, junk otherwise.
  always @(posedge clk) begin
    zpipe[0] <= dct_en ? dct_f(dct_x, mode) : {8{12'hA5A}};
    for (int i = 1; i < LAT; i++) zpipe[i] <= zpipe[i-1];
  end
  assign dct_z = zpipe[LAT-1];

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic push_samples(input int n, input int pct);
    int    sent;
    int    guard;
    beat_t e;
    sent = 0;
    guard = 0;
    while (sent < n) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(99) < pct);
      bus.in_sample = bus.in_valid ? stim_q[0] : 8'($urandom);
      if (bus.in_valid && bus.in_ready) begin
        acc_q.push_back(stim_q.pop_front());
        sent++;
        t_acc = cyc + 1;
        if (acc_q.size() == 8) begin
          for (int k = 0; k < 8; k++) begin
            e.idx  = 3'(k);
            e.last = (k == 7);
            e.coef = mode ? 12'(int'($signed(acc_q[k])) * 4 + k) : 12'(k * 100);
            exp_q.push_back(e);
          end
          acc_q.delete();
        end
      end
      guard++;
      if (guard > 2000) begin
        total++; bad++;
        $display("FAIL push_timeout sent=%0d want=%0d", sent, n);
        break;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // rmode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random.
  task automatic drain_block(input int rmode, output int first_cyc);
    int          got;
    int          guard;
    int          ph;
    logic        r;
    logic        stalled;
    logic [16:0] held;
    logic [16:0] now_v;
    beat_t       e;
    got = 0; guard = 0; ph = 0; stalled = 1'b0; held = '0; first_cyc = -1;
    while (got < 8) begin
      @(negedge clk);
      now_v = {bus.out_valid, bus.out_coef, bus.out_idx, bus.out_last};
      if (stalled) begin
        total++;
        if (now_v !== held) begin
          bad++;
          $display("FAIL stall_hold got=%h want=%h", now_v, held);
        end
      end
      if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
      case (rmode)
        0:       r = 1'b1;
        1:       r = (ph % 3 == 0);
        default: r = 1'($urandom_range(1));
      endcase
      if (bus.out_valid) ph++;
      bus.out_ready = r;
      stalled = bus.out_valid && !r;
      held = now_v;
      if (bus.out_valid && r) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_empty got_idx=%0d", bus.out_idx);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_coef, bus.out_idx, bus.out_last} !== e) begin
            bad++;
            $display("FAIL beat got coef=%0d idx=%0d last=%0b want coef=%0d idx=%0d last=%0b",
                     $signed(bus.out_coef), bus.out_idx, bus.out_last, $signed(e.coef), e.idx, e.last);
          end
        end
        got++;
      end
      guard++;
      if (guard > 500) begin
        total++; bad++;
        $display("FAIL drain_timeout got=%0d want=8", got);
        break;
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_drain got valid=%b in_ready=%b want valid=0 in_ready=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
  endtask

  task automatic check_blk(input string name);
    total++;
    if (blk_cnt !== 16'(exp_blk)) begin
      bad++;
      $display("FAIL %s blk_cnt got=%0d want=%0d", name, blk_cnt, 16'(exp_blk));
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++;
    if ({dct_en, dct_cs, busy} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {dct_en, dct_cs, busy}); end
    total++;
    if (dct_x !== 64'd0) begin bad++; $display("FAIL reset_dct_x got=%h want=0", dct_x); end
    total++;
    if ({bus.out_valid, bus.out_coef, bus.out_idx, bus.out_last} !== 17'd0) begin
      bad++;
      $display("FAIL reset_out got=%h want=0", {bus.out_valid, bus.out_coef, bus.out_idx, bus.out_last});
    end
    total++;
    if (blk_cnt !== 16'd0) begin bad++; $display("FAIL reset_blk_cnt got=%0d want=0", blk_cnt); end
  endtask

  task automatic test_basic();
    int fc;
    int en0;
    int cs0;
    mode = 1'b0;
    for (int i = 0; i < 8; i++) stim_q.push_back(8'(i));
    en0 = en_cnt;
    cs0 = cs_cnt;
    push_samples(8, 100);
    drain_block(0, fc);
    exp_blk++;
    total++;
    if (fc - t_acc !== LAT + 2) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", fc - t_acc, LAT + 2); end
    total++;
    if (en_cnt - en0 !== LAT + 1) begin bad++; $display("FAIL basic_en_window got=%0d want=%0d", en_cnt - en0, LAT + 1); end
    total++;
    if (cs_cnt - cs0 !== LAT + 1) begin bad++; $display("FAIL basic_cs_window got=%0d want=%0d", cs_cnt - cs0, LAT + 1); end
    total++;
    if (dct_x !== 64'h0706050403020100) begin bad++; $display("FAIL basic_dct_x got=%h want=0706050403020100", dct_x); end
    check_blk("basic");
  endtask

  task automatic test_backpressure();
    int fc;
    mode = 1'b1;
    load_random(8);
    push_samples(8, 100);
    drain_block(1, fc);
    exp_blk++;
    check_blk("backpressure");
  endtask

  task automatic test_input_gaps();
    int fc;
    mode = 1'b1;
    stim_q.push_back(8'h80);
    stim_q.push_back(8'h7F);
    load_random(22);
    for (int b = 0; b < 3; b++) begin
      push_samples(8, 30);
      drain_block(2, fc);
      exp_blk++;
    end
    check_blk("input_gaps");
  endtask

  task automatic test_clr_fill();
    int fc;
    mode = 1'b1;
    load_random(5);
    push_samples(5, 100);
    @(negedge clk);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sample = 8'h55;
    @(negedge clk);
    clr = 1'b0;
    bus.in_valid = 1'b0;
    acc_q.delete();
    stim_q.delete();
    load_random(8);
    push_samples(8, 100);
    drain_block(0, fc);
    exp_blk++;
    check_blk("clr_fill");
  endtask

  task automatic test_clr_drain();
    int    guard;
    beat_t e;
    mode = 1'b1;
    load_random(8);
    push_samples(8, 100);
    guard = 0;
    while (1) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (bus.out_valid && bus.out_idx == 3'd3) begin
        clr = 1'b1;
        break;
      end
      if (bus.out_valid) begin
        e = exp_q.pop_front();
        total++;
        if ({bus.out_coef, bus.out_idx, bus.out_last} !== e) begin
          bad++;
          $display("FAIL clr_drain_beat got idx=%0d coef=%0d want idx=%0d coef=%0d",
                   bus.out_idx, $signed(bus.out_coef), e.idx, $signed(e.coef));
        end
      end
      guard++;
      if (guard > 100) begin
        total++; bad++;
        $display("FAIL clr_drain_timeout got=none want=idx3");
        break;
      end
    end
    @(negedge clk);
    clr = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    total++;
    if ({bus.out_valid, busy, bus.in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL clr_drain_state got valid,busy,in_ready=%b want=001", {bus.out_valid, busy, bus.in_ready});
    end
    check_blk("clr_drain");
  endtask

  task automatic test_wrap();
    int fc;
    mode = 1'b1;
    @(negedge clk);
    force dut.blk_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.blk_cnt;
    exp_blk = 16'hFFFF;
    check_blk("wrap_preload");
    load_random(8);
    push_samples(8, 100);
    drain_block(0, fc);
    exp_blk = 0;
    check_blk("wrap");
  endtask

  task automatic test_async_reset();
    int fc;
    mode = 1'b1;
    load_random(8);
    push_samples(8, 100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, dct_en, dct_cs, bus.in_ready, bus.out_valid} !== 5'b00010) begin
      bad++;
      $display("FAIL areset_ctl got=%b want=00010", {busy, dct_en, dct_cs, bus.in_ready, bus.out_valid});
    end
    total++;
    if (dct_x !== 64'd0 || blk_cnt !== 16'd0) begin
      bad++;
      $display("FAIL areset_data got dct_x=%h blk_cnt=%0d want 0 0", dct_x, blk_cnt);
    end
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    exp_blk = 0;
    load_random(8);
    push_samples(8, 100);
    drain_block(0, fc);
    exp_blk++;
    check_blk("areset_after");
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_backpressure();
    test_input_gaps();
    test_clr_fill();
    test_clr_drain();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
